mult_div_unit: RTL

Multiply/divide unit with its own sequencing logic. It sits in the E stage beside the ALU and executes mult, multu, div, divu, mfhi, mflo, mthi and mtlo. It owns the HI/LO registers. A cycle counter models the multi-cycle latency of the operation and raises `busy`, which the hazard unit uses to stall later MD instructions in D.

---
 rtl/mult_div_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the E stage. Results are computed at accept time
// and held in pending registers until a cycle counter models the operation latency.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        md_start,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdOp_e;

    typedef enum logic {
        IDLE,
        RUN
    } mdState_e;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hiPend_q, hiPend_d;
    logic [31:0] loPend_q, loPend_d;
    logic        commit_q, commit_d;
    mdState_e    state;

    logic [63:0] prodS, prodU;
    logic [31:0] divisorU, magA, magB, quoMag, remMag, quoS, remS, quoU, remU;

    assign state    = (cnt_q != 4'd0) ? RUN : IDLE;
    assign busy     = (state == RUN);
    assign md_start = (md_op >= OP_MULT) && (md_op <= OP_DIVU) && !busy;
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_comb begin
        md_out = 32'd0;
        if (md_op == OP_MFHI) begin
            md_out = hi_q;
        end else if (md_op == OP_MFLO) begin
            md_out = lo_q;
        end
    end

    // Signed divide works on magnitudes so the quotient truncates toward zero and the
    // remainder follows the dividend; a zero divisor is replaced to keep values defined.
    always_comb begin
        prodS    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prodU    = {32'd0, a} * {32'd0, b};
        divisorU = (b == 32'd0) ? 32'd1 : b;
        quoU     = a / divisorU;
        remU     = a % divisorU;
        magA     = a[31] ? (32'd0 - a) : a;
        magB     = (b == 32'd0) ? 32'd1 : (b[31] ? (32'd0 - b) : b);
        quoMag   = magA / magB;
        remMag   = magA % magB;
        quoS     = (a[31] ^ b[31]) ? (32'd0 - quoMag) : quoMag;
        remS     = a[31] ? (32'd0 - remMag) : remMag;
    end

    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hiPend_d = hiPend_q;
        loPend_d = loPend_q;
        commit_d = commit_q;
        if (state == RUN) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1 && commit_q) begin
                hi_d = hiPend_q;
                lo_d = loPend_q;
            end
        end else begin
            case (md_op)
                OP_MULT: begin
                    hiPend_d = prodS[63:32];
                    loPend_d = prodS[31:0];
                    commit_d = 1'b1;
                    cnt_d    = MULT_LOAD;
                end
                OP_MULTU: begin
                    hiPend_d = prodU[63:32];
                    loPend_d = prodU[31:0];
                    commit_d = 1'b1;
                    cnt_d    = MULT_LOAD;
                end
                OP_DIV: begin
                    hiPend_d = remS;
                    loPend_d = quoS;
                    commit_d = (b != 32'd0);
                    cnt_d    = DIV_LOAD;
                end
                OP_DIVU: begin
                    hiPend_d = remU;
                    loPend_d = quoU;
                    commit_d = (b != 32'd0);
                    cnt_d    = DIV_LOAD;
                end
                OP_MTHI: hi_d = a;
                OP_MTLO: lo_d = a;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 4'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hiPend_q <= 32'd0;
            loPend_q <= 32'd0;
            commit_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hiPend_q <= hiPend_d;
            loPend_q <= loPend_d;
            commit_q <= commit_d;
        end
    end

endmodule
